// File: rtl/cpu_pkg.sv
// Shared decode encodings, condition codes, FSM state and control bundle
// for the decode control stage.
package cpu_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic {
    ISSUE    = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic       b;
    logic       s;
    logic       imm;
    logic       mul;
    logic [3:0] exe_cmd;
  } ctrl_t;

  // {wb_en, exe_cmd} for a data-processing opcode
  function automatic logic [4:0] alu_map(input logic [3:0] op);
    logic [4:0] r;
    r = {1'b0, EXE_NOP};
    unique case (op)
      OP_MOV:  r = {1'b1, EXE_MOV};
      OP_MVN:  r = {1'b1, EXE_MVN};
      OP_ADD:  r = {1'b1, EXE_ADD};
      OP_ADC:  r = {1'b1, EXE_ADC};
      OP_SUB:  r = {1'b1, EXE_SUB};
      OP_SBC:  r = {1'b1, EXE_SBC};
      OP_AND:  r = {1'b1, EXE_AND};
      OP_ORR:  r = {1'b1, EXE_ORR};
      OP_EOR:  r = {1'b1, EXE_EOR};
      OP_CMP:  r = {1'b0, EXE_SUB};
      OP_TST:  r = {1'b0, EXE_AND};
      default: r = {1'b0, EXE_NOP};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation against NZCV flags.
// NV (1111) never passes.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = status;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode control stage with valid/ready handshake and optional multiply
// sequencer enabled by macro DECODE_MUL_EN.
module decode_ctrl_pipe
  import cpu_pkg::*;
#(
  parameter int EXE_CMD_W = 4,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [3:0]           status,
  input  logic                 hazard,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 wb_en,
  output logic                 mem_r,
  output logic                 mem_w,
  output logic                 b,
  output logic                 s,
  output logic                 imm,
  output logic                 mul,
  output logic [EXE_CMD_W-1:0] exe_cmd
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  ctrl_t      dec, ctl_q;
  logic       pass, xfer, take;
  logic [1:0] mode;
  logic [3:0] op;
  logic       sbit;
  logic       unused_instr;

  assign mode = instr[27:26];
  assign op   = instr[24:21];
  assign sbit = instr[20];
  assign unused_instr = ^instr[19:0];

  cond_check u_cond (
    .cond   (instr[31:28]),
    .status (status),
    .pass   (pass)
  );

  assign in_ready = !rst && !hazard
                 && (!out_valid || out_ready)
                 && (state == ISSUE);
  assign xfer = in_valid && in_ready;
  assign take = out_valid && out_ready;

`ifdef DECODE_MUL_EN
  logic is_mul;
  assign is_mul = (instr[27:22] == 6'b000000)
               && (instr[7:4] == 4'b1001);
`endif

  always_comb begin
    dec = '0;
    unique case (mode)
      MODE_ALU: begin
        dec.s   = sbit;
        dec.imm = instr[25];
`ifdef DECODE_MUL_EN
        if (is_mul) begin
          dec.mul     = 1'b1;
          dec.wb_en   = 1'b1;
          dec.exe_cmd = EXE_NOP;
        end else begin
          {dec.wb_en, dec.exe_cmd} = alu_map(op);
        end
`else
        {dec.wb_en, dec.exe_cmd} = alu_map(op);
`endif
      end
      MODE_MEM: begin
        dec.s       = sbit;
        dec.imm     = instr[25];
        dec.exe_cmd = EXE_ADD;
        dec.mem_r   = sbit;
        dec.mem_w   = !sbit;
        dec.wb_en   = sbit;
      end
      MODE_BR: begin
        dec.b   = 1'b1;
        dec.imm = instr[25];
      end
      default: dec = '0;
    endcase
  end

  // Leave MUL_BUSY only once the count is spent and execute can accept
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ISSUE: begin
        if (xfer && pass && dec.mul) begin
          state_nxt = MUL_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      MUL_BUSY: begin
        cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
        if (cnt_nxt == 4'd0 && out_ready)
          state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
    if (flush) begin
      state_nxt = ISSUE;
      cnt_nxt   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISSUE;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      ctl_q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flush) begin
        out_valid <= 1'b0;
        ctl_q     <= '0;
      end else if (xfer) begin
        out_valid <= pass;
        ctl_q     <= pass ? dec : '0;
      end else if (take) begin
        out_valid <= 1'b0;
        ctl_q     <= '0;
      end
    end
  end

  assign wb_en   = ctl_q.wb_en;
  assign mem_r   = ctl_q.mem_r;
  assign mem_w   = ctl_q.mem_w;
  assign b       = ctl_q.b;
  assign s       = ctl_q.s;
  assign imm     = ctl_q.imm;
  assign mul     = ctl_q.mul;
  assign exe_cmd = EXE_CMD_W'(ctl_q.exe_cmd);

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter EXE_CMD_W, default 4, giving the ALU command width (minimum 4).
REQ-002 SHALL have parameter MUL_LAT, default 3, giving the multiply occupancy in cycles (range 2..15).
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): fetch-side handshake.
REQ-006 SHALL have port instr, input, 32: ARM-format instruction.
REQ-007 SHALL have port status, input, 4: NZCV flags (bit3 N .. bit0 V).
REQ-008 SHALL have ports hazard (input, 1: hold, no consume) and flush (input, 1: kill stage contents).
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): execute-side handshake.
REQ-010 SHALL have outputs wb_en, mem_r, mem_w, b, s, imm, mul (1 each) and exe_cmd (EXE_CMD_W), all registered.

Function
REQ-011 SHALL transfer an input when in_valid && in_ready; in_ready = !hazard && (!out_valid || out_ready) && state==ISSUE.
REQ-012 SHALL decode mode = instr[27:26], opcode = instr[24:21], S = instr[20], cond = instr[31:28].
REQ-013 SHALL map mode 00 opcodes to exe_cmd, zero-extended: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP 0100, TST 0110; other opcodes give 0000 with wb_en=0.
REQ-014 SHALL set wb_en=1 for mode-00 ops except CMP/TST; s=S for mode 00 and mode 01; s=0 for mode 10.
REQ-015 SHALL decode mode 01 as LDR (S=1: mem_r=1, wb_en=1) or STR (S=0: mem_w=1, wb_en=0), exe_cmd 0010.
REQ-016 SHALL decode mode 10 as branch: b=1, wb_en=0, exe_cmd 0000; imm = instr[25].
REQ-017 SHALL evaluate cond against status (EQ..LE, AL=1110; 1111 treated as never); a failing condition consumes the instruction and loads a bubble (out_valid=0, all controls 0).
REQ-018 SHALL provide one-cycle latency: transfer in cycle n gives out_valid=1 with decoded controls in cycle n+1.
REQ-019 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid when the output is taken and no new transfer occurs.
REQ-021 SHALL, on flush, load a bubble next cycle, return the FSM to ISSUE and clear the counter; flush wins over a simultaneous transfer or hazard.
REQ-022 SHALL not consume an instruction while hazard=1; hazard does not clear a held output.
REQ-023 SHALL implement FSM states ISSUE and MUL_BUSY (see REQ-029).

Reset
REQ-024 SHALL, when rst=1 at a clk edge, set out_valid, wb_en, mem_r, mem_w, b, s, imm, mul to 0 and exe_cmd to 0, state to ISSUE and the counter to 0.
REQ-025 SHALL give rst priority over flush, hazard and handshakes, including mid-MUL_BUSY.
REQ-026 SHALL hold in_ready=0 during the reset cycle.

Configuration
REQ-027 SHALL use macro DECODE_MUL_EN to gate the multiply sequencer.
REQ-028 SHALL, with DECODE_MUL_EN undefined, treat instr[27:22]==000000 && instr[7:4]==1001 as an ordinary mode-00 op; mul is tied 0 and the FSM stays in ISSUE.
REQ-029 SHALL, with DECODE_MUL_EN defined, decode that pattern as MUL: mul=1, wb_en=1, exe_cmd 0000; on transfer, enter MUL_BUSY, load counter MUL_LAT-1 and drop in_ready; decrement each cycle, returning to ISSUE when the counter reaches 0 and out_ready=1.

Structure
REQ-030 SHALL place the exe_cmd encodings, mode codes, cond codes and the FSM state type in shared package cpu_pkg.
REQ-031 SHALL use one sub-module, cond_check (cond, status -> pass), combinational.

Verification
REQ-032 SHALL check: instr 0xE0821003 (ADD, AL) -> next cycle out_valid=1, exe_cmd=0010, wb_en=1, s=0.
REQ-033 SHALL check: instr 0x01510002 (CMPEQ) with status=0000 -> out_valid=0, in_ready=1 next cycle.
REQ-034 SHALL check: instr 0xE5910000 (LDR) with out_ready=0 for 3 cycles -> mem_r=1, wb_en=1 held, in_ready=0.
REQ-035 SHALL check: with DECODE_MUL_EN defined and MUL_LAT=3, instr 0xE0000291 -> mul=1; in_ready low for 2 cycles, then high.
REQ-036 SHALL check: flush asserted in MUL_BUSY -> next cycle out_valid=0, state ISSUE, in_ready=1.
REQ-037 SHALL check: rst asserted with out_valid=1 -> all outputs 0 on the next edge.
